// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: bundle of timing, writer, VRAM and DAC signals around vram_scan_arbiter
//   slave  : arbiter side (takes blank/sync/writer/rdata, drives ack/VRAM/DAC)
//   master : environment side (counters, pixel writer, VRAM model, DAC)
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 6
);
  logic              active_low_hblank;
  logic              active_low_vblank;
  logic              active_low_hsync;
  logic              active_low_vsync;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_out;
  logic              hsync_out;
  logic              vsync_out;
  modport slave (
    input  active_low_hblank, active_low_vblank, active_low_hsync, active_low_vsync,
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_wdata, mem_we, pix_out, hsync_out, vsync_out
  );
  modport master (
    output active_low_hblank, active_low_vblank, active_low_hsync, active_low_vsync,
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_wdata, mem_we, pix_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares a single-port VRAM between display scan-out and a blanking-only pixel writer
//   i_clk_in           : pixel clock, all logic on posedge
//   i_active_low_reset : synchronous active-low reset
//   io_bus             : counters (blank/sync), writer handshake, VRAM port, DAC pixel and delayed syncs
module vram_scan_arbiter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 6
) (
  input logic           i_clk_in,
  input logic           i_active_low_reset,
  vram_scan_arbiter_if.slave io_bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  typedef enum logic [1:0] {ST_SCAN, ST_BLANK, ST_WRITE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_pix;
  logic              r_mem_we, r_wr_ack;
  logic [1:0]        r_hs, r_vs;
  logic              w_active;
  assign w_active = io_bus.active_low_hblank & io_bus.active_low_vblank;
  // a write cycle is always followed by a non-write cycle so the writer can drop/advance its request
  always_comb begin
    w_next = ST_BLANK;
    w_next = w_active ? ST_SCAN : (io_bus.wr_req && r_state != ST_WRITE) ? ST_WRITE : ST_BLANK;
  end
  always_ff @(posedge i_clk_in)
    r_state <= !i_active_low_reset ? ST_BLANK : w_next;
  always_ff @(posedge i_clk_in) begin
    if (!i_active_low_reset) begin
      r_ptr       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_pix       <= '0;
      r_hs        <= 2'b11;
      r_vs        <= 2'b11;
    end else begin
      r_mem_we <= w_next == ST_WRITE;
      r_wr_ack <= w_next == ST_WRITE;
      if (w_next == ST_SCAN) r_mem_addr <= r_ptr;
      else if (w_next == ST_WRITE) begin
        r_mem_addr  <= io_bus.wr_addr;
        r_mem_wdata <= io_bus.wr_data;
      end
      // vertical blanking realigns the scan pointer to the top of the frame
      r_ptr <= !io_bus.active_low_vblank ? '0 :
               (w_next == ST_SCAN) ? ((r_ptr == LAST) ? '0 : r_ptr + 1'b1) : r_ptr;
      // read data belongs to the address presented in the cycle that just ended
      r_pix <= (r_state == ST_SCAN) ? io_bus.mem_rdata : '0;
      r_hs  <= {r_hs[0], io_bus.active_low_hsync};
      r_vs  <= {r_vs[0], io_bus.active_low_vsync};
    end
  end
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.wr_ack    = r_wr_ack;
  assign io_bus.pix_out   = r_pix;
  assign io_bus.hsync_out = r_hs[1];
  assign io_bus.vsync_out = r_vs[1];
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: self-checking bench for vram_scan_arbiter
module tb_vram_scan_arbiter;
  localparam int AW = 19, DW = 6, LAST = 800 * 600 - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  vram_scan_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  vram_scan_arbiter dut (.i_clk_in(clk), .i_active_low_reset(rst_n), .io_bus(bus));
  assign bus.mem_rdata = bus.mem_addr[DW-1:0];
  typedef struct packed {logic [DW-1:0] pix; logic hs; logic vs;} sb_t;
  typedef struct {logic req; logic [AW-1:0] a; logic [DW-1:0] d; logic ack; logic [AW-1:0] ea; logic [DW-1:0] ed;} vec_t;
  sb_t  sb[$];
  vec_t tbl[10];
  int   checks = 0, failures = 0, ptr = 0, acks = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    ptr = 0;
    sb.delete();
    sb.push_back('{'0, 1'b1, 1'b1});
  endtask
  task automatic step(input logic hb, input logic vb, input logic hs, input logic vs, input logic req,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic act;
    int   ea;
    sb_t  e;
    act = hb & vb;
    ea  = ptr;
    bus.active_low_hblank = hb;
    bus.active_low_vblank = vb;
    bus.active_low_hsync  = hs;
    bus.active_low_vsync  = vs;
    bus.wr_req  = req;
    bus.wr_addr = a;
    bus.wr_data = d;
    sb.push_back('{act ? DW'(ptr) : '0, hs, vs});
    if (!vb) ptr = 0;
    else if (act) ptr = (ptr == LAST) ? 0 : ptr + 1;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("pix_out", 32'(bus.pix_out), 32'(e.pix));
    chk("hsync_out", 32'(bus.hsync_out), 32'(e.hs));
    chk("vsync_out", 32'(bus.vsync_out), 32'(e.vs));
    if (act) begin
      chk("scan_addr", 32'(bus.mem_addr), ea);
      chk("scan_we", 32'(bus.mem_we), 0);
      chk("scan_ack", 32'(bus.wr_ack), 0);
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 19'd1234, 6'h2A, 1'b1, 19'd1234, 6'h2A};
    tbl[1] = '{1'b1, 19'd2000, 6'h01, 1'b0, 19'd1234, 6'h2A};
    tbl[2] = '{1'b1, 19'd2000, 6'h01, 1'b1, 19'd2000, 6'h01};
    tbl[3] = '{1'b1, 19'd2001, 6'h02, 1'b0, 19'd2000, 6'h01};
    tbl[4] = '{1'b1, 19'd2001, 6'h02, 1'b1, 19'd2001, 6'h02};
    tbl[5] = '{1'b1, 19'd2002, 6'h03, 1'b0, 19'd2001, 6'h02};
    tbl[6] = '{1'b1, 19'd2002, 6'h03, 1'b1, 19'd2002, 6'h03};
    tbl[7] = '{1'b1, 19'd2003, 6'h04, 1'b0, 19'd2002, 6'h03};
    tbl[8] = '{1'b1, 19'd2003, 6'h04, 1'b1, 19'd2003, 6'h04};
    tbl[9] = '{1'b0, 19'd2003, 6'h04, 1'b0, 19'd2003, 6'h04};
    bus.active_low_hblank = 1'b0;
    bus.active_low_vblank = 1'b0;
    bus.active_low_hsync  = 1'b1;
    bus.active_low_vsync  = 1'b1;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    do_reset(3);
    chk("reset_we", 32'(bus.mem_we), 0);
    chk("reset_ack", 32'(bus.wr_ack), 0);
    chk("reset_pix", 32'(bus.pix_out), 0);
    chk("reset_hsync", 32'(bus.hsync_out), 1);
    chk("reset_vsync", 32'(bus.vsync_out), 1);
    chk("reset_addr", 32'(bus.mem_addr), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i >= 2, 1'b0, '0, '0);
    for (int i = 0; i < 800; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, !(i >= 2 && i < 6), 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b1, 1'b1, i >= 100, 19'd1234, 6'h2A);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, tbl[i].req, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_ack", i), 32'(bus.wr_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].ed));
      if (bus.wr_ack) acks++;
    end
    chk("blank_write_count", acks, 5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd777, 6'h15);
    chk("edge_write_ack", 32'(bus.wr_ack), 1);
    chk("edge_write_addr", 32'(bus.mem_addr), 777);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("frame_first_addr", 32'(bus.mem_addr), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd555, 6'h3F);
    chk("prereset_ack", 32'(bus.wr_ack), 1);
    chk("prereset_we", 32'(bus.mem_we), 1);
    do_reset(1);
    chk("midwrite_reset_we", 32'(bus.mem_we), 0);
    chk("midwrite_reset_ack", 32'(bus.wr_ack), 0);
    chk("midwrite_reset_pix", 32'(bus.pix_out), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd556, 6'h11);
    chk("rerequest_ack", 32'(bus.wr_ack), 1);
    chk("rerequest_addr", 32'(bus.mem_addr), 556);
    chk("rerequest_wdata", 32'(bus.mem_wdata), 32'h11);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("post_reset_ptr", 32'(bus.mem_addr), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
